// File: rtl/uart_rx_if.sv
// Receive-side bus of the debug UART: serial line in, FIFO read port and sticky status out.
// master = consumer/line driver side, slave = uart_rx.
interface uart_rx_if;
  logic       rx_in;
  logic       rd_en_in;
  logic       clr_err_in;
  logic [7:0] rx_data_out;
  logic       rx_empty_out;
  logic       rx_full_out;
  logic       overflow_err_out;
  logic       frame_err_out;
  logic       parity_err_out;

  modport master (
    output rx_in, rd_en_in, clr_err_in,
    input  rx_data_out, rx_empty_out, rx_full_out,
    input  overflow_err_out, frame_err_out, parity_err_out
  );

  modport slave (
    input  rx_in, rd_en_in, clr_err_in,
    output rx_data_out, rx_empty_out, rx_full_out,
    output overflow_err_out, frame_err_out, parity_err_out
  );
endinterface

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a first-word-fall-through FIFO with sticky overflow/frame/parity flags.
module uart_rx #(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int BAUD_RATE    = 38400,
  parameter int FIFO_AW      = 3
) (
  input  logic     clk_in,
  input  logic     rst_in,
  uart_rx_if.slave bus
);

  localparam int DIV   = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic             sync1_q, sync2_q, rx_s;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  state_t      state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        armed_q, armed_d;
  logic        push_q, push_d;
  logic [7:0]  push_byte_q, push_byte_d;
  logic        par_bad_q, par_bad_d;
  logic        frame_ev, parity_ev;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic [7:0]       data_q, data_d;
  logic             overflow_q, overflow_d, frame_q, frame_d, parity_q, parity_d;
  logic             pop, wr_en, overflow_ev;

  assign rx_s = sync2_q;
  assign tick = (tick_cnt_q == CNT_W'(DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= bus.rx_in;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    par_bad_d   = par_bad_q;
    frame_ev    = 1'b0;
    parity_ev   = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          // After a low stop bit the line must be seen high before a new start is accepted.
          if (!armed_q) begin
            if (rx_s) armed_d = 1'b1;
          end else if (!rx_s) begin
            state_d   = S_START;
            sc_d      = 4'd0;
            par_bad_d = 1'b0;
          end
        end
        S_START: begin
          if (sc_q == 4'd7) begin
            sc_d      = 4'd0;
            bit_idx_d = 3'd0;
            state_d   = rx_s ? S_IDLE : S_DATA;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        S_DATA: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            par_bad_d = ^{shift_q, rx_s};
            parity_ev = ^{shift_q, rx_s};
            state_d   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            state_d     = S_IDLE;
            armed_d     = rx_s;
            frame_ev    = ~rx_s;
            push_d      = rx_s & ~par_bad_q;
            push_byte_d = shift_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      sc_q        <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      armed_q     <= 1'b1;
      push_q      <= 1'b0;
      push_byte_q <= 8'd0;
      par_bad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      par_bad_q   <= par_bad_d;
    end
  end

  always_comb begin
    pop         = bus.rd_en_in & ~empty_q;
    wr_en       = push_q & (~full_q | pop);
    overflow_ev = push_q & full_q & ~pop;
    rd_ptr_d    = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    wr_ptr_d    = wr_ptr_q + {{FIFO_AW{1'b0}}, wr_en};
    empty_d     = (rd_ptr_d == wr_ptr_d);
    full_d      = (rd_ptr_d[FIFO_AW] != wr_ptr_d[FIFO_AW]) &&
                  (rd_ptr_d[FIFO_AW-1:0] == wr_ptr_d[FIFO_AW-1:0]);
    // Head register tracks the next head; bypass when the head is the entry being written now.
    if (empty_d)
      data_d = data_q;
    else if (wr_en && (rd_ptr_d == wr_ptr_q))
      data_d = push_byte_q;
    else
      data_d = mem[rd_ptr_d[FIFO_AW-1:0]];
    overflow_d = (overflow_q & ~bus.clr_err_in) | overflow_ev;
    frame_d    = (frame_q & ~bus.clr_err_in) | frame_ev;
    parity_d   = (parity_q & ~bus.clr_err_in) | parity_ev;
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= push_byte_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      data_q     <= 8'd0;
      overflow_q <= 1'b0;
      frame_q    <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      frame_q    <= frame_d;
      parity_q   <= parity_d;
    end
  end

  assign bus.rx_data_out      = data_q;
  assign bus.rx_empty_out     = empty_q;
  assign bus.rx_full_out      = full_q;
  assign bus.overflow_err_out = overflow_q;
  assign bus.frame_err_out    = frame_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err_out   = parity_q;
`else
  assign bus.parity_err_out   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=1 (16 clk per bit); exercises parity frames when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int lat;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  uart_rx_if bus();

  uart_rx #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .FIFO_AW(3)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame; lat = negedges into the stop bit at which the FIFO first reads non-empty.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par,
                            input logic pop_on_push, output int lat_o);
    logic par_bit;
    par_bit = (^b) ^ bad_par;
    lat_o = -1;
    $display("frame byte=0x%02h stop=%0b bad_par=%0b pop_on_push=%0b", b, stop_bit, bad_par, pop_on_push);
    bus.rx_in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = b[i];
      repeat (16) @(negedge clk);
    end
    if (PAR_EN) begin
      bus.rx_in = par_bit;
      repeat (16) @(negedge clk);
    end
    bus.rx_in = stop_bit;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (lat_o < 0 && !bus.rx_empty_out) lat_o = k;
      if (pop_on_push && k == 11) bus.rd_en_in = 1'b1;
      if (k == 12) bus.rd_en_in = 1'b0;
    end
  endtask

  task automatic pop_one();
    bus.rd_en_in = 1'b1;
    @(negedge clk);
    bus.rd_en_in = 1'b0;
  endtask

  task automatic clr_err();
    bus.clr_err_in = 1'b1;
    @(negedge clk);
    bus.clr_err_in = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_data"},  32'(bus.rx_data_out), 32'h0);
    chk({tag, "_empty"}, 32'(bus.rx_empty_out), 32'h1);
    chk({tag, "_full"},  32'(bus.rx_full_out), 32'h0);
    chk({tag, "_ovf"},   32'(bus.overflow_err_out), 32'h0);
    chk({tag, "_frm"},   32'(bus.frame_err_out), 32'h0);
    chk({tag, "_par"},   32'(bus.parity_err_out), 32'h0);
  endtask

  initial begin
    bus.rx_in = 1'b1;
    bus.rd_en_in = 1'b0;
    bus.clr_err_in = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_state("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_state("idle");

    // Single byte, push latency and pop
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, lat);
    chk("a5_latency", 32'(lat), 32'd12);
    chk("a5_empty", 32'(bus.rx_empty_out), 32'h0);
    chk("a5_data", 32'(bus.rx_data_out), 32'hA5);
    pop_one();
    chk("a5_pop_empty", 32'(bus.rx_empty_out), 32'h1);

    // Start-bit glitch
    bus.rx_in = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_empty", 32'(bus.rx_empty_out), 32'h1);
    chk("glitch_frm", 32'(bus.frame_err_out), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, lat);
    chk("3c_data", 32'(bus.rx_data_out), 32'h3C);
    pop_one();

    // Framing error, then a long break must not raise another event
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, lat);
    chk("frm_set", 32'(bus.frame_err_out), 32'h1);
    chk("frm_empty", 32'(bus.rx_empty_out), 32'h1);
    clr_err();
    chk("frm_clr", 32'(bus.frame_err_out), 32'h0);
    repeat (640) @(negedge clk);
    chk("break_frm", 32'(bus.frame_err_out), 32'h0);
    chk("break_empty", 32'(bus.rx_empty_out), 32'h1);
    bus.rx_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("break_end_frm", 32'(bus.frame_err_out), 32'h0);

    // Overflow: 9 bytes into 8 entries
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0, lat);
      if (i == 7) begin
        chk("ovf_full8", 32'(bus.rx_full_out), 32'h1);
        chk("ovf_none8", 32'(bus.overflow_err_out), 32'h0);
      end
    end
    chk("ovf_full9", 32'(bus.rx_full_out), 32'h1);
    chk("ovf_set", 32'(bus.overflow_err_out), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_drain%0d", i), 32'(bus.rx_data_out), 32'(i));
      pop_one();
    end
    chk("ovf_drained", 32'(bus.rx_empty_out), 32'h1);
    clr_err();
    chk("ovf_clr", 32'(bus.overflow_err_out), 32'h0);

    // Full boundary: pop on the push cycle of the 9th byte
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, 1'b0, lat);
    send_frame(8'h18, 1'b1, 1'b0, 1'b1, lat);
    chk("fb_ovf", 32'(bus.overflow_err_out), 32'h0);
    chk("fb_full", 32'(bus.rx_full_out), 32'h1);
    chk("fb_head", 32'(bus.rx_data_out), 32'h11);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fb_drain%0d", i), 32'(bus.rx_data_out), 32'(8'h11 + i));
      pop_one();
    end
    chk("fb_drained", 32'(bus.rx_empty_out), 32'h1);

    // Reset mid-frame with a byte queued and a frame error pending
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, lat);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, lat);
    bus.rx_in = 1'b1;
    repeat (32) @(negedge clk);
    chk("pre_rst_frm", 32'(bus.frame_err_out), 32'h1);
    chk("pre_rst_data", 32'(bus.rx_data_out), 32'h5A);
    $display("frame byte=0xff interrupted by reset at data bit 4");
    bus.rx_in = 1'b0;
    repeat (16) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (72) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("midrst_held");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk_reset_state("midrst");
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, lat);
    chk("81_empty", 32'(bus.rx_empty_out), 32'h0);
    chk("81_data", 32'(bus.rx_data_out), 32'h81);
    pop_one();

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, lat);
      chk("par_ok_data", 32'(bus.rx_data_out), 32'h07);
      chk("par_ok_flag", 32'(bus.parity_err_out), 32'h0);
      pop_one();
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, lat);
      chk("par_bad_flag", 32'(bus.parity_err_out), 32'h1);
      chk("par_bad_empty", 32'(bus.rx_empty_out), 32'h1);
      chk("par_bad_frm", 32'(bus.frame_err_out), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
